pwm_deadtime: RTL and testbench

Downstream gate-drive stage for the `pwm` peripheral. It takes the per-channel PWM levels and produces complementary high-side/low-side drive pairs. Each pair has a programmable break-before-make dead interval, per-channel enable and output polarity, and a global latched kill (fault) input. It sits on the same b16 I/O bus as `pwm`, with its own `sel`, and uses the same byte-lane write and combinational read conventions.

---
 rtl/pwm_deadtime_if.sv | 13 +
 rtl/pwm_deadtime.sv | 162 ++++++++++++++++
 tb/tb_pwm_deadtime.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadtime_if.sv
// b16 I/O bus slice seen by pwm_deadtime: select, strobes, address, write data
// and the combinational read data returned by the block.
interface pwm_deadtime_if;
  logic        sel;
  logic        r;
  logic [1:0]  w;
  logic [5:0]  addr;
  logic [15:0] dwrite;
  logic [15:0] dt_data;

  modport master (output sel, r, w, addr, dwrite, input dt_data);
  modport slave  (input sel, r, w, addr, dwrite, output dt_data);
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate drive with break-before-make dead time per channel,
// per-channel enable/polarity and a latched global kill.
module pwm_dt_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pol,
  input  logic        fault,
  input  logic        kill,
  input  logic        pwm,
  input  logic [15:0] dt,
  output logic        hi,
  output logic        lo
);
  typedef enum logic [1:0] {OFF, DEAD, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hi_q, hi_d, lo_q, lo_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en || fault || kill) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DEAD;
          cnt_d   = dt;
        end
        DEAD: begin
          if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
          else                state_d = pwm ? HIGH : LOW;
        end
        HIGH: if (!pwm) begin
          state_d = DEAD;
          cnt_d   = dt;
        end
        LOW: if (pwm) begin
          state_d = DEAD;
          cnt_d   = dt;
        end
        default: state_d = OFF;
      endcase
    end
    // pol is the post-edge polarity so hi/lo always match the stored CTRL value
    hi_d = (state_d == HIGH) ^ pol;
    lo_d = (state_d == LOW)  ^ pol;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q   <= 16'd0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

module pwm_deadtime #(
  parameter int pwms = 2
) (
  input  logic            clk,
  input  logic            reset,
  pwm_deadtime_if.slave   bus,
  input  logic [pwms:0]   pwm_in,
  input  logic            kill,
  output logic [pwms:0]   hi,
  output logic [pwms:0]   lo
);
  localparam int NCH = pwms + 1;

  logic [NCH-1:0][15:0] dt_q, dt_d;
  logic [NCH-1:0]       en_q, en_d, pol_q, pol_d;
  logic                 fault_q, fault_d;
  logic [1:0]           ch;
  logic                 acc_ok;
  logic [15:0]          rdata;

  assign ch     = bus.addr[3:2];
  assign acc_ok = (bus.addr[1:0] == 2'b00) && (int'(ch) <= pwms);

  always_comb begin
    dt_d    = dt_q;
    en_d    = en_q;
    pol_d   = pol_q;
    fault_d = fault_q;
    if (bus.sel && acc_ok) begin
      case (bus.addr[5:4])
        2'd0: begin
          if (bus.w[0]) dt_d[ch][7:0]  = bus.dwrite[7:0];
          if (bus.w[1]) dt_d[ch][15:8] = bus.dwrite[15:8];
        end
        2'd1: if (bus.w[0]) begin
          en_d[ch]  = bus.dwrite[0];
          pol_d[ch] = bus.dwrite[1];
        end
        2'd2: if (ch == 2'd0 && bus.w[0] && bus.dwrite[0]) fault_d = 1'b0;
        default: ;
      endcase
    end
    // kill beats a same-edge software clear
    if (kill) fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dt_q    <= {NCH{16'h0010}};
      en_q    <= '0;
      pol_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      dt_q    <= dt_d;
      en_q    <= en_d;
      pol_q   <= pol_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (bus.r && bus.sel && acc_ok) begin
      case (bus.addr[5:4])
        2'd0: rdata = dt_q[ch];
        2'd1: rdata = {14'd0, pol_q[ch], en_q[ch]};
        2'd2: if (ch == 2'd0) begin
          rdata[0]       = fault_q;
          rdata[1]       = kill;
          rdata[8 +: NCH] = pwm_in;
        end
        default: ;
      endcase
    end
  end

  assign bus.dt_data = rdata;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    pwm_dt_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (en_q[i]),
      .pol   (pol_d[i]),
      .fault (fault_q),
      .kill  (kill),
      .pwm   (pwm_in[i]),
      .dt    (dt_q[i]),
      .hi    (hi[i]),
      .lo    (lo[i])
    );
  end
endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a timeline model predicts hi/lo every edge
// and read data per access; a negedge monitor compares against the DUT.
module tb_pwm_deadtime;
  localparam int PWMS = 2;
  localparam int NCH  = PWMS + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [PWMS:0]   pwm_in;
  logic            kill;
  logic [PWMS:0]   hi, lo;

  pwm_deadtime_if bus();

  pwm_deadtime #(.pwms(PWMS)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pwm_in (pwm_in),
    .kill   (kill),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  longint now_c = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: channel is idle, waiting out a gap until an absolute
  // release edge, or driving one side.
  typedef enum {IDLE, GAP, DRV_H, DRV_L} mode_t;
  logic [15:0] m_dt   [NCH];
  logic        m_en   [NCH];
  logic        m_pol  [NCH];
  mode_t       m_mode [NCH];
  longint      m_rel  [NCH];
  logic        m_fault;

  logic [2*NCH-1:0] exp_q[$];
  logic [15:0]      rd_q[$];

  function automatic logic [15:0] exp_rd(input logic [5:0] a);
    int          c;
    logic [15:0] v;
    c = int'(a[3:2]);
    v = 16'h0000;
    if (a[1:0] == 2'b00 && c <= PWMS) begin
      case (a[5:4])
        2'd0: v = m_dt[c];
        2'd1: v = {14'd0, m_pol[c], m_en[c]};
        2'd2: if (c == 0) begin
          v[0] = m_fault;
          v[1] = kill;
          v[8 +: NCH] = pwm_in;
        end
        default: v = 16'h0000;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin
    logic [NCH-1:0] he, le;
    int c;
    now_c++;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_dt[i] = 16'h0010; m_en[i] = 1'b0; m_pol[i] = 1'b0; m_mode[i] = IDLE; m_rel[i] = 0;
      end
      m_fault = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!m_en[i] || m_fault || kill) m_mode[i] = IDLE;
        else case (m_mode[i])
          IDLE:  begin m_mode[i] = GAP; m_rel[i] = now_c + longint'(m_dt[i]) + 1; end
          GAP:   if (now_c == m_rel[i]) m_mode[i] = pwm_in[i] ? DRV_H : DRV_L;
          DRV_H: if (!pwm_in[i]) begin m_mode[i] = GAP; m_rel[i] = now_c + longint'(m_dt[i]) + 1; end
          DRV_L: if (pwm_in[i])  begin m_mode[i] = GAP; m_rel[i] = now_c + longint'(m_dt[i]) + 1; end
          default: m_mode[i] = IDLE;
        endcase
      end
      c = int'(bus.addr[3:2]);
      if (bus.sel && bus.addr[1:0] == 2'b00 && c <= PWMS) begin
        case (bus.addr[5:4])
          2'd0: begin
            if (bus.w[0]) m_dt[c][7:0]  = bus.dwrite[7:0];
            if (bus.w[1]) m_dt[c][15:8] = bus.dwrite[15:8];
          end
          2'd1: if (bus.w[0]) begin m_en[c] = bus.dwrite[0]; m_pol[c] = bus.dwrite[1]; end
          2'd2: if (c == 0 && bus.w[0] && bus.dwrite[0] && !kill) m_fault = 1'b0;
          default: ;
        endcase
      end
      if (kill) m_fault = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      he[i] = (m_mode[i] == DRV_H) ^ m_pol[i];
      le[i] = (m_mode[i] == DRV_L) ^ m_pol[i];
    end
    exp_q.push_back({he, le});
  end

  always @(negedge clk) begin
    logic [2*NCH-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hilo", 32'({hi, lo}), 32'(e));
    end
    if (bus.r && bus.sel) begin
      if (rd_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
      else                  chk("rdata", 32'(bus.dt_data), 32'(rd_q.pop_front()));
    end else begin
      chk("rd_idle", 32'(bus.dt_data), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] we);
    bus.sel = 1'b1; bus.r = 1'b0; bus.addr = a; bus.dwrite = d; bus.w = we;
    tick();
    bus.sel = 1'b0; bus.w = 2'b00;
  endtask

  task automatic rd(input logic [5:0] a);
    bus.sel = 1'b1; bus.r = 1'b1; bus.addr = a; bus.w = 2'b00;
    rd_q.push_back(exp_rd(a));
    tick();
    bus.sel = 1'b0; bus.r = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    logic [5:0] a;
    reset = 1'b1; kill = 1'b0; pwm_in = '0;
    bus.sel = 1'b0; bus.r = 1'b0; bus.w = 2'b00; bus.addr = 6'd0; bus.dwrite = 16'd0;
    tick();
    kill = 1'b1;
    wr(6'd0, 16'h1234, 2'b11);
    kill = 1'b0;
    tick();
    reset = 1'b0;
    rd(6'd0);
    rd(6'd20);

    wr(6'd0, 16'd3, 2'b11);
    pwm_in[0] = 1'b1;
    wr(6'd16, 16'd1, 2'b01);
    k = 0;
    while (!hi[0] && k < 40) begin tick(); k++; end
    chk("hi0_rise_latency", 32'(k), 32'd5);
    pwm_in[0] = 1'b0;
    tick();
    chk("hi0_fall", 32'(hi[0]), 32'd0);
    k = 0;
    while (!lo[0] && k < 40) begin tick(); k++; end
    chk("lo0_rise_latency", 32'(k), 32'd4);

    wr(6'd4, 16'd0, 2'b11);
    wr(6'd20, 16'd1, 2'b01);
    repeat (4) tick();
    pwm_in[1] = 1'b1; tick();
    pwm_in[1] = 1'b0; repeat (6) tick();

    wr(6'd24, 16'd1, 2'b01);
    pwm_in[2] = 1'b1;
    repeat (20) tick();
    kill = 1'b1; tick(); kill = 1'b0;
    chk("kill_off", 32'({hi, lo}), 32'd0);
    rd(6'd32);
    kill = 1'b1; wr(6'd32, 16'd1, 2'b01); kill = 1'b0;
    rd(6'd32);
    wr(6'd32, 16'd1, 2'b01);
    k = 0;
    while (!lo[0] && k < 40) begin tick(); k++; end
    chk("clear_restart_latency", 32'(k), 32'd5);

    wr(6'd24, 16'd2, 2'b01);
    tick();
    chk("pol_idle", 32'({hi[2], lo[2]}), 32'd3);
    wr(6'd8, 16'hAB00, 2'b10);
    rd(6'd8);
    wr(6'd24, 16'd0, 2'b01);

    rd(6'd12); rd(6'd2); rd(6'd28); rd(6'd48);
    wr(6'd12, 16'hFFFF, 2'b11);
    wr(6'd1,  16'hFFFF, 2'b11);
    wr(6'd28, 16'h0003, 2'b01);
    wr(6'd18, 16'h0003, 2'b01);
    rd(6'd0); rd(6'd4); rd(6'd8); rd(6'd16); rd(6'd20); rd(6'd24);

    for (int it = 0; it < 2500; it++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) pwm_in[c] = ~pwm_in[c];
      kill = ($urandom_range(0, 99) == 0);
      a = {2'b00, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 31))
        0:       wr(a, 16'($urandom_range(0, 5)), 2'($urandom_range(1, 3)));
        1, 2:    wr(a | 6'd16, 16'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        3:       wr(6'd32, 16'd1, 2'b01);
        4, 5:    rd(6'($urandom_range(0, 63)));
        6, 7:    rd(a | 6'(16 * $urandom_range(0, 3)));
        default: tick();
      endcase
    end
    kill = 1'b0;
    repeat (5) tick();
    chk("rdq_drain", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
